// File: rtl/t07_spitft_rx.sv
// rtl/t07_spitft_rx.sv - SPI TFT receiver: 64-bit interleaved address/data frame to parallel word
// Optional overrun detection: define T07_SPITFT_RX_OVERRUN_EN.
module t07_spitft_rx (
  input  logic        clk,
  input  logic        nrst,
  input  logic        chipSelect,
  input  logic        sclk,
  input  logic        bitData,
  input  logic        ready_i,
  output logic [31:0] address_o,
  output logic [31:0] data_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS} state_t;

  state_t      state, state_nx;
  logic        cs_s1, cs_s2;
  logic        sclk_s1, sclk_s2, sclk_s3;
  logic        bd_s1, bd_s2;
  logic        sclk_rise;
  logic [6:0]  bit_cnt;
  logic [63:0] shreg;
  logic [1:0]  arm_cnt;
  logic        armed;
  logic        cnt_clr, shift_en, err_set;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      bd_s1   <= 1'b0;
      bd_s2   <= 1'b0;
    end else begin
      cs_s1   <= chipSelect;
      cs_s2   <= cs_s1;
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      bd_s1   <= bitData;
      bd_s2   <= bd_s1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_s3;

  // The synchronizer resets to chipSelect=1, so a frame still in progress at
  // reset release would look like a fresh one; only arm once cs_s2 carries a
  // genuinely sampled high level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      arm_cnt <= 2'd0;
      armed   <= 1'b0;
    end else begin
      if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
      if (arm_cnt[1] && cs_s2) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  // Deassertion wins over a coincident sclk edge.
  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !cs_s2) begin
          cnt_clr  = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_s2) begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == 7'd63) state_nx = DONE;
        end
      end
      DONE:    state_nx = WAIT_CS;
      WAIT_CS: if (cs_s2) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bit_cnt <= 7'd0;
      shreg   <= 64'd0;
    end else if (cnt_clr) begin
      bit_cnt <= 7'd0;
      shreg   <= 64'd0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 7'd1;
      shreg   <= {shreg[62:0], bd_s2};
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      address_o   <= 32'd0;
      data_o      <= 32'd0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= err_set;
      if (state == DONE) begin
        address_o <= {shreg[63:56], shreg[47:40], shreg[31:24], shreg[15:8]};
        data_o    <= {shreg[55:48], shreg[39:32], shreg[23:16], shreg[7:0]};
        valid_o   <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state == SHIFT) || (state == DONE);

`ifdef T07_SPITFT_RX_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                       overrun_q <= 1'b0;
    else if ((state == DONE) && valid_o && !ready_i) overrun_q <= 1'b1;
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_t07_spitft_rx.sv
// tb/tb_t07_spitft_rx.sv - directed scoreboard bench for t07_spitft_rx
module tb_t07_spitft_rx;

  logic        clk;
  logic        nrst;
  logic        chipSelect;
  logic        sclk;
  logic        bitData;
  logic        ready_i;
  logic [31:0] address_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        busy_o;
  logic        frame_err_o;
  logic        overrun_o;

  int compared   = 0;
  int mismatched = 0;
  int valid_cycles = 0;
  int err_pulses   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] rx_q[$];

`ifdef T07_SPITFT_RX_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  t07_spitft_rx dut (
    .clk         (clk),
    .nrst        (nrst),
    .chipSelect  (chipSelect),
    .sclk        (sclk),
    .bitData     (bitData),
    .ready_i     (ready_i),
    .address_o   (address_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nrst && valid_o) valid_cycles <= valid_cycles + 1;
    if (frame_err_o) err_pulses <= err_pulses + 1;
    if (nrst && valid_o && ready_i) rx_q.push_back({address_o, data_o});
  end

  function automatic logic [63:0] mk(input logic [31:0] a, input logic [31:0] d);
    return {a[31:24], d[31:24], a[23:16], d[23:16], a[15:8], d[15:8], a[7:0], d[7:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [63:0] v, input int nbits, input bit finish, input int gap);
    chipSelect = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < 64) bitData = v[63-i];
      else        bitData = 1'b1;
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
    if (finish) begin
      repeat (4) @(negedge clk);
      chipSelect = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic check_word(input string tag);
    logic [63:0] got, exp;
    int n;
    n = 0;
    while (rx_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    compared++;
    assert (rx_q.size() != 0 && exp_q.size() != 0) else begin
      mismatched++;
      $error("FAIL %s_timeout observed=%0d expected=1", tag, rx_q.size());
    end
    if (rx_q.size() != 0 && exp_q.size() != 0) begin
      got = rx_q.pop_front();
      exp = exp_q.pop_front();
      check({tag, "_addr"}, {32'd0, got[63:32]}, {32'd0, exp[63:32]});
      check({tag, "_data"}, {32'd0, got[31:0]},  {32'd0, exp[31:0]});
    end
  endtask

  initial begin
    int vc0, ep0;
    nrst = 1'b0; chipSelect = 1'b1; sclk = 1'b0; bitData = 1'b0; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr",  {32'd0, address_o}, 64'd0);
    check("rst_data",  {32'd0, data_o}, 64'd0);
    check("rst_valid", {63'd0, valid_o}, 64'd0);
    check("rst_busy",  {63'd0, busy_o}, 64'd0);
    check("rst_err",   {63'd0, frame_err_o}, 64'd0);
    check("rst_ovr",   {63'd0, overrun_o}, 64'd0);
    nrst = 1'b1;
    repeat (6) @(negedge clk);

    // basic frame, literal stream
    vc0 = valid_cycles; ep0 = err_pulses;
    exp_q.push_back({32'h12345678, 32'hDEADBEEF});
    send_frame(64'h12DE34AD56BE78EF, 64, 1, 6);
    check_word("basic");
    check("basic_vcyc", 64'(valid_cycles - vc0), 64'd1);
    check("basic_err",  64'(err_pulses - ep0), 64'd0);

    // short frame abort
    vc0 = valid_cycles; ep0 = err_pulses;
    send_frame(mk(32'hCAFEF00D, 32'h0BADC0DE), 20, 1, 8);
    check("abort_err",  64'(err_pulses - ep0), 64'd1);
    check("abort_vcyc", 64'(valid_cycles - vc0), 64'd0);
    check("abort_addr", {32'd0, address_o}, {32'd0, 32'h12345678});
    check("abort_data", {32'd0, data_o}, {32'd0, 32'hDEADBEEF});
    exp_q.push_back({32'hA1B2C3D4, 32'h55667788});
    send_frame(mk(32'hA1B2C3D4, 32'h55667788), 64, 1, 6);
    check_word("after_abort");

    // 70 edges in one frame
    vc0 = valid_cycles;
    exp_q.push_back({32'h0F0F1234, 32'h87654321});
    send_frame(mk(32'h0F0F1234, 32'h87654321), 70, 0, 0);
    check("long_busy", {63'd0, busy_o}, 64'd0);
    chipSelect = 1'b1;
    repeat (6) @(negedge clk);
    check_word("long");
    check("long_vcyc", 64'(valid_cycles - vc0), 64'd1);

    // overwrite while not ready
    ready_i = 1'b0;
    send_frame(mk(32'h11111111, 32'hAAAAAAAA), 64, 1, 6);
    send_frame(mk(32'h22222222, 32'hBBBBBBBB), 64, 1, 6);
    check("ovw_addr",  {32'd0, address_o}, {32'd0, 32'h22222222});
    check("ovw_data",  {32'd0, data_o}, {32'd0, 32'hBBBBBBBB});
    check("ovw_valid", {63'd0, valid_o}, 64'd1);
    check("ovw_ovr",   {63'd0, overrun_o}, {63'd0, EXP_OVR});
    exp_q.push_back({32'h22222222, 32'hBBBBBBBB});
    ready_i = 1'b1;
    @(negedge clk);
    check_word("ovw");
    check("ovw_vclr", {63'd0, valid_o}, 64'd0);

    // back-to-back frames, minimum gap
    vc0 = valid_cycles; ep0 = err_pulses;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({32'h30000000 + 32'(k), 32'hC0000000 + 32'(k * 17)});
      send_frame(mk(32'h30000000 + 32'(k), 32'hC0000000 + 32'(k * 17)), 64, 1, 3);
    end
    check_word("b2b0");
    check_word("b2b1");
    check_word("b2b2");
    check("b2b_vcyc", 64'(valid_cycles - vc0), 64'd3);
    check("b2b_err",  64'(err_pulses - ep0), 64'd0);

    // reset in the middle of a frame
    ep0 = err_pulses;
    send_frame(mk(32'h44444444, 32'h55555555), 40, 0, 0);
    #2 nrst = 1'b0;
    #1;
    check("mrst_addr",  {32'd0, address_o}, 64'd0);
    check("mrst_data",  {32'd0, data_o}, 64'd0);
    check("mrst_valid", {63'd0, valid_o}, 64'd0);
    check("mrst_busy",  {63'd0, busy_o}, 64'd0);
    check("mrst_ovr",   {63'd0, overrun_o}, 64'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sclk = 1'b1; repeat (4) @(negedge clk);
      sclk = 1'b0; repeat (4) @(negedge clk);
    end
    check("mrst_idle_busy", {63'd0, busy_o}, 64'd0);
    check("mrst_noerr", 64'(err_pulses - ep0), 64'd0);
    chipSelect = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back({32'h9ABCDEF0, 32'h13579BDF});
    send_frame(mk(32'h9ABCDEF0, 32'h13579BDF), 64, 1, 6);
    check_word("mrst_next");
    check("end_q", 64'(rx_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
